// File: rtl/temp_conv_pkg.sv
// Shared types and conversion constants for the Celsius/Fahrenheit converter.
package temp_conv_pkg;

  typedef enum logic {
    C2F = 1'b0,
    F2C = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    DIV,
    FIX,
    DONE
  } state_e;

  localparam int unsigned MulC2f   = 9;
  localparam int unsigned DivC2f   = 5;
  localparam int unsigned OffF     = 32;
  localparam int unsigned OffC2f   = 160;
  localparam int unsigned DivisorW = 4;

endpackage

// File: rtl/temp_conv_div.sv
// Restoring shift/subtract divider, one quotient bit per clock, MSB first.
module temp_conv_div #(
  parameter int unsigned DW = 14,
  parameter int unsigned VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
);
  localparam int unsigned CW = $clog2(DW + 1);

  logic [DW-1:0] quo_q;
  logic [VW-1:0] rem_q, dsr_q;
  logic [CW-1:0] cnt_q;
  logic [VW:0]   trial, diff;
  logic          fits;

  assign trial = {rem_q, quo_q[DW-1]};
  assign diff  = trial - {1'b0, dsr_q};
  assign fits  = trial >= {1'b0, dsr_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      quo_q <= dividend;
      rem_q <= '0;
      dsr_q <= divisor;
      cnt_q <= CW'(DW);
    end else if (cnt_q != '0) begin
      quo_q <= {quo_q[DW-2:0], fits};
      rem_q <= fits ? diff[VW-1:0] : trial[VW-1:0];
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // High while the final step is being taken; results are valid after this edge.
  assign done      = (cnt_q == CW'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/temp_conv.sv
// Sequential C<->F converter with rounding; define TEMP_CONV_SAT_EN to saturate
// out-of-range results and flag ovf, otherwise results wrap to W bits.
module temp_conv
  import temp_conv_pkg::*;
#(
  parameter int unsigned W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mode,
  input  logic signed [W-1:0] temp_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] temp_out,
  output logic                ovf
);
  localparam int unsigned NW = W + 5;
  localparam int unsigned MW = W + 4;

  state_e              state_q;
  mode_e               mode_q;
  logic signed [W-1:0] temp_q, temp_out_q, res_out;
  logic                neg_q, in_ready_q, out_valid_q, ovf_q, res_ovf;

  logic signed [NW-1:0] t_ext, num, res;
  logic [MW-1:0]        mag, div_quo, q_rnd;
  logic [DivisorW-1:0]  divisor, div_rem;
  logic                 div_start, div_done, round_up;

  assign t_ext = NW'(temp_q);

  always_comb begin
    if (mode_q == C2F) begin
      num = t_ext * $signed(NW'(MulC2f)) + $signed(NW'(OffC2f));
    end else begin
      num = (t_ext - $signed(NW'(OffF))) * $signed(NW'(DivC2f));
    end
  end

  assign mag       = num[NW-1] ? MW'(-num) : MW'(num);
  assign divisor   = (mode_q == C2F) ? DivisorW'(DivC2f) : DivisorW'(MulC2f);
  assign div_start = (state_q == PREP);

  temp_conv_div #(
    .DW(MW),
    .VW(DivisorW)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (mag),
    .divisor  (divisor),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  // Half away from zero on the magnitude, then restore the sign.
  assign round_up = {div_rem, 1'b0} >= {1'b0, divisor};
  assign q_rnd    = div_quo + MW'(round_up);
  assign res      = neg_q ? -$signed({1'b0, q_rnd}) : $signed({1'b0, q_rnd});

`ifdef TEMP_CONV_SAT_EN
  logic in_range;
  always_comb begin
    in_range = (&res[NW-1:W-1]) | ~(|res[NW-1:W-1]);
    res_ovf  = ~in_range;
    if (in_range)        res_out = res[W-1:0];
    else if (res[NW-1])  res_out = {1'b1, {(W-1){1'b0}}};
    else                 res_out = {1'b0, {(W-1){1'b1}}};
  end
`else
  logic unused_res_hi;
  assign unused_res_hi = ^res[NW-1:W];
  assign res_ovf       = 1'b0;
  assign res_out       = res[W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= C2F;
      temp_q      <= '0;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      temp_out_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          mode_q     <= mode_e'(mode);
          temp_q     <= temp_in;
          in_ready_q <= 1'b0;
          state_q    <= PREP;
        end
        PREP: begin
          neg_q   <= num[NW-1];
          state_q <= DIV;
        end
        DIV: if (div_done) state_q <= FIX;
        FIX: begin
          temp_out_q  <= res_out;
          ovf_q       <= res_ovf;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign temp_out  = temp_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_temp_conv.sv
// Bench for temp_conv at W=10: vector table plus random requests through a scoreboard queue.
module tb_temp_conv;
  localparam int unsigned W = 10;

  logic                clk = 1'b0;
  logic                rst_n, in_valid, in_ready, mode, out_valid, out_ready, ovf;
  logic signed [W-1:0] temp_in, temp_out;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic m;
    int   t;
    int   exp_o;
    logic exp_ov;
    int   stall;
  } vec_t;

  typedef struct {
    int   o;
    logic ov;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  temp_conv #(
    .W(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .temp_in  (temp_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .temp_out (temp_out),
    .ovf      (ovf)
  );

  task automatic check(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  // Reference: exact integer conversion, rounded half away from zero.
  function automatic void model(input logic m, input int t, output int o, output logic ov);
    int n, d, a, q, r;
    logic [W-1:0] lo;
    if (!m) begin n = 9 * t + 160; d = 5; end
    else    begin n = 5 * (t - 32); d = 9; end
    a = (n < 0) ? -n : n;
    q = (2 * a + d) / (2 * d);
    r = (n < 0) ? -q : q;
    lo = r[W-1:0];
`ifdef TEMP_CONV_SAT_EN
    if (r > 511)       begin o = 511;  ov = 1'b1; end
    else if (r < -512) begin o = -512; ov = 1'b1; end
    else               begin o = r;    ov = 1'b0; end
`else
    o  = int'($signed(lo));
    ov = 1'b0;
`endif
  endfunction

  task automatic run_one(input logic m, input int t, input int exp_o, input logic exp_ov,
                         input int stall);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (!in_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    mode     = m;
    temp_in  = W'(t);
    sb.push_back('{exp_o, exp_ov});
    @(posedge clk); #1;
    // Disturb inputs while busy; they must not affect the result.
    in_valid = 1'b0;
    mode     = ~m;
    temp_in  = W'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check("latency", cyc, 16);
    e = sb.pop_front();
    check("temp_out", int'(temp_out), e.o);
    check("ovf", ovf, e.ov);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      temp_in  = W'($urandom);
      @(posedge clk); #1;
      check("hold_temp_out", int'(temp_out), e.o);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("consume_out_valid", out_valid, 0);
    check("consume_in_ready", in_ready, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    int   o;
    logic ov, m, saw;
    int   t;

    vecs[0] = '{1'b0, 100, 212, 1'b0, 0};
    vecs[1] = '{1'b0, -40, -40, 1'b0, 0};
    vecs[2] = '{1'b1, 98, 37, 1'b0, 0};
    vecs[3] = '{1'b1, 0, -18, 1'b0, 0};
`ifdef TEMP_CONV_SAT_EN
    vecs[4] = '{1'b0, 511, 511, 1'b1, 0};
    vecs[5] = '{1'b0, -512, -512, 1'b1, 0};
`else
    vecs[4] = '{1'b0, 511, -72, 1'b0, 0};
    vecs[5] = '{1'b0, -512, 134, 1'b0, 0};
`endif
    vecs[6] = '{1'b1, -512, -302, 1'b0, 0};
    vecs[7] = '{1'b0, 100, 212, 1'b0, 20};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = 1'b0;
    temp_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_temp_out", int'(temp_out), 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      run_one(vecs[i].m, vecs[i].t, vecs[i].exp_o, vecs[i].exp_ov, vecs[i].stall);
    end

    for (int i = 0; i < 6; i++) begin
      m = 1'($urandom_range(0, 1));
      t = int'($urandom_range(0, 1023)) - 512;
      model(m, t, o, ov);
      run_one(m, t, o, ov, 0);
    end

    // Abandon a request mid-division with an asynchronous reset.
    in_valid = 1'b1;
    mode     = 1'b0;
    temp_in  = W'(100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_temp_out", int'(temp_out), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_in_ready", in_ready, 1);
    saw = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    check("aborted_no_result", saw, 0);
    run_one(1'b1, 212, 100, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
